// File: rtl/tile_loader.sv
// tile_loader: streams a row-major tile into T single-port banks, one bank per tile row.
// Optional TILE_LOADER_ZERO_PAD_EN zeroes banks rows..T-1 over the loaded columns.
module tile_loader #(
   parameter int W  = 8,
   parameter int T  = 4,
   parameter int AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       tile_rows,
   input  logic [15:0]       tile_cols,
   input  logic              bankset_sel,
   output logic              busy,
   output logic              done,
   input  logic              in_valid,
   input  logic [W-1:0]      in_data,
   output logic              in_ready,
   output logic [T-1:0]      b_we,
   output logic [T*AW-1:0]   b_addr,
   output logic [T*W-1:0]    b_din
);

   localparam int CW   = AW - 1;
   localparam int RW   = (T > 1) ? $clog2(T) : 1;
   localparam int NW   = $clog2(T + 1);
   localparam int CMAX = 1 << CW;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PAD  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e            state_q;
   logic [NW-1:0]     rows_q, rows_d;
   logic [AW-1:0]     cols_q, cols_d;
   logic              bs_q;
   logic [RW-1:0]     r_q;
   logic [CW-1:0]     c_q;
   logic              busy_q, done_q, in_ready_q;
   logic [T-1:0]      b_we_q;
   logic [T*AW-1:0]   b_addr_q;
   logic [T*W-1:0]    b_din_q;
   logic              hs, last_col, last_row;

   // Clamp requested geometry so r and c can never overflow their counters.
   always_comb begin
      rows_d = (tile_rows > 16'(T))    ? NW'(T)    : tile_rows[NW-1:0];
      cols_d = (tile_cols > 16'(CMAX)) ? AW'(CMAX) : tile_cols[AW-1:0];
   end

   assign hs       = in_ready_q && in_valid;
   assign last_col = ({1'b0, c_q} == (cols_q - AW'(1)));
   assign last_row = (NW'(r_q) == (rows_q - NW'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rows_q     <= '0;
         cols_q     <= '0;
         bs_q       <= 1'b0;
         r_q        <= '0;
         c_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         in_ready_q <= 1'b0;
         b_we_q     <= '0;
         b_addr_q   <= '0;
         b_din_q    <= '0;
      end else begin
         b_we_q <= '0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  rows_q <= rows_d;
                  cols_q <= cols_d;
                  bs_q   <= bankset_sel;
                  r_q    <= '0;
                  c_q    <= '0;
                  busy_q <= 1'b1;
                  if ((rows_d == '0) || (cols_d == '0)) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= S_LOAD;
                     in_ready_q <= 1'b1;
                  end
               end
            end

            S_LOAD: begin
               if (hs) begin
                  b_we_q[r_q]                <= 1'b1;
                  b_addr_q[r_q*AW +: AW]     <= {bs_q, c_q};
                  b_din_q[r_q*W +: W]        <= in_data;
                  if (last_col) begin
                     c_q <= '0;
                     if (last_row) begin
                        in_ready_q <= 1'b0;
`ifdef TILE_LOADER_ZERO_PAD_EN
                        if (rows_q < NW'(T)) begin
                           state_q <= S_PAD;
                        end else begin
                           state_q <= S_DONE;
                           done_q  <= 1'b1;
                        end
`else
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
`endif
                     end else begin
                        r_q <= r_q + RW'(1);
                     end
                  end else begin
                     c_q <= c_q + CW'(1);
                  end
               end
            end

`ifdef TILE_LOADER_ZERO_PAD_EN
            // One column per cycle; every bank above the loaded rows gets a zero.
            S_PAD: begin
               for (int k = 0; k < T; k++) begin
                  if (NW'(k) >= rows_q) begin
                     b_we_q[k]            <= 1'b1;
                     b_addr_q[k*AW +: AW] <= {bs_q, c_q};
                     b_din_q[k*W +: W]    <= '0;
                  end
               end
               if (last_col) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  c_q <= c_q + CW'(1);
               end
            end
`endif

            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q    <= S_IDLE;
               busy_q     <= 1'b0;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign in_ready = in_ready_q;
   assign b_we     = b_we_q;
   assign b_addr   = b_addr_q;
   assign b_din    = b_din_q;

endmodule

// File: tb/tb_tile_loader.sv
// Self-checking bench for tile_loader: expected bank writes are queued as stimulus is
// driven and popped by a write monitor; scenario tasks check timing and counts inline.
module tb_tile_loader;

   localparam int W  = 8;
   localparam int T  = 4;
   localparam int AW = 8;
   localparam int EW = 8 + AW + W;

`ifdef TILE_LOADER_ZERO_PAD_EN
   localparam int PAD_EN = 1;
`else
   localparam int PAD_EN = 0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [15:0]     tile_rows, tile_cols;
   logic            bankset_sel;
   logic            busy, done;
   logic            in_valid;
   logic [W-1:0]    in_data;
   logic            in_ready;
   logic [T-1:0]    b_we;
   logic [T*AW-1:0] b_addr;
   logic [T*W-1:0]  b_din;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int wr_cnt    = 0;
   int cyc       = 0;

   logic [EW-1:0] exp_q[$];

   tile_loader #(.W(W), .T(T), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .tile_rows   (tile_rows),
      .tile_cols   (tile_cols),
      .bankset_sel (bankset_sel),
      .busy        (busy),
      .done        (done),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .b_we        (b_we),
      .b_addr      (b_addr),
      .b_din       (b_din)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: every strobed bank must match the head of the expected queue
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         for (int k = 0; k < T; k++) begin
            if (b_we[k] === 1'b1) begin : mon
               logic [EW-1:0] got;
               logic [EW-1:0] exp;
               got = {8'(k), b_addr[k*AW +: AW], b_din[k*W +: W]};
               wr_cnt++;
               total_cnt++;
               if (exp_q.size() == 0) begin
                  $display("FAIL write_unexpected: got bank/addr/data %h, expected no write", got);
               end else begin
                  exp = exp_q.pop_front();
                  if (got !== exp)
                     $display("FAIL write_data: got bank/addr/data %h, expected %h", got, exp);
                  else
                     pass_cnt++;
               end
            end
         end
      end
   end

   // driver: one tile load, returns observed timing; caller sits #1 after a posedge
   task automatic drive_load(input int tr, input int tc, input int bs, input int base,
                             input int stall, output int start_cyc, output int hs_cyc,
                             output int done_cyc, output int hs_n, output logic ir_after,
                             output logic busy_after);
      int rr, cc, n, idx, guard;
      rr = (tr > T) ? T : tr;
      cc = (tc > (1 << (AW-1))) ? (1 << (AW-1)) : tc;
      n  = rr * cc;
      for (int i = 0; i < n; i++)
         exp_q.push_back({8'(i / cc), 1'(bs), (AW-1)'(i % cc), W'(base + i)});
      if (PAD_EN != 0 && n > 0 && rr < T)
         for (int c = 0; c < cc; c++)
            for (int k = rr; k < T; k++)
               exp_q.push_back({8'(k), 1'(bs), (AW-1)'(c), W'(0)});

      start       = 1'b1;
      tile_rows   = 16'(tr);
      tile_cols   = 16'(tc);
      bankset_sel = 1'(bs);
      @(negedge clk);
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;

      idx = 0; guard = 0; hs_cyc = -1;
      while (idx < n && guard < 2000) begin
         in_valid = (stall != 0) ? (guard % 3 == 0) : 1'b1;
         in_data  = W'(base + idx);
         @(negedge clk);
         if (in_valid && in_ready === 1'b1) begin
            hs_cyc = cyc;
            idx++;
         end
         @(posedge clk); #1;
         guard++;
      end
      hs_n = idx;

      // keep offering data: nothing more may be consumed once the tile is in
      in_valid = 1'b1;
      in_data  = 8'hEE;
      done_cyc = -1;
      ir_after = 1'bx;
      for (int g = 0; g < 400; g++) begin
         @(negedge clk);
         if (g == 0) ir_after = in_ready;
         if (done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      busy_after = busy;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; tile_rows = '0; tile_cols = '0; bankset_sel = 1'b0;
      in_valid = 1'b0; in_data = '0;
      repeat (2) @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else pass_cnt++;
      total_cnt++; if (b_we !== '0) $display("FAIL reset_b_we: got %h expected 0", b_we); else pass_cnt++;
      total_cnt++; if (b_addr !== '0) $display("FAIL reset_b_addr: got %h expected 0", b_addr); else pass_cnt++;
      total_cnt++; if (b_din !== '0) $display("FAIL reset_b_din: got %h expected 0", b_din); else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_2x3();
      int s, h, d, hn, w0; logic ir, ba;
      w0 = wr_cnt;
      drive_load(2, 3, 0, 1, 0, s, h, d, hn, ir, ba);
      total_cnt++; if (wr_cnt - w0 !== 6 + PAD_EN*6) $display("FAIL basic_writes: got %0d expected %0d", wr_cnt - w0, 6 + PAD_EN*6); else pass_cnt++;
      total_cnt++; if (d !== h + 1 + PAD_EN*3) $display("FAIL basic_done_cycle: got %0d expected %0d", d, h + 1 + PAD_EN*3); else pass_cnt++;
      total_cnt++; if (ba !== 1'b0) $display("FAIL basic_busy_after: got %b expected 0", ba); else pass_cnt++;
      total_cnt++; if (exp_q.size() !== 0) $display("FAIL basic_missing: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_bankset1_4x4();
      int s, h, d, hn, w0; logic ir, ba;
      w0 = wr_cnt;
      drive_load(4, 4, 1, 16, 0, s, h, d, hn, ir, ba);
      total_cnt++; if (wr_cnt - w0 !== 16) $display("FAIL full_writes: got %0d expected 16", wr_cnt - w0); else pass_cnt++;
      total_cnt++; if (h - s !== 16) $display("FAIL full_load_cycles: got %0d expected 16", h - s); else pass_cnt++;
      total_cnt++; if (ir !== 1'b0) $display("FAIL full_ready_after: got %b expected 0", ir); else pass_cnt++;
      total_cnt++; if (d !== h + 1) $display("FAIL full_done_cycle: got %0d expected %0d", d, h + 1); else pass_cnt++;
      total_cnt++; if (exp_q.size() !== 0) $display("FAIL full_missing: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_stall_2x2();
      int s, h, d, hn, w0; logic ir, ba;
      w0 = wr_cnt;
      drive_load(2, 2, 0, 64, 1, s, h, d, hn, ir, ba);
      total_cnt++; if (wr_cnt - w0 !== 4 + PAD_EN*4) $display("FAIL stall_writes: got %0d expected %0d", wr_cnt - w0, 4 + PAD_EN*4); else pass_cnt++;
      total_cnt++; if (hn !== 4) $display("FAIL stall_handshakes: got %0d expected 4", hn); else pass_cnt++;
      total_cnt++; if (d !== h + 1 + PAD_EN*2) $display("FAIL stall_done_cycle: got %0d expected %0d", d, h + 1 + PAD_EN*2); else pass_cnt++;
      total_cnt++; if (exp_q.size() !== 0) $display("FAIL stall_missing: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_pad_1x2();
      int s, h, d, hn, w0; logic ir, ba;
      w0 = wr_cnt;
      drive_load(1, 2, 0, 7, 0, s, h, d, hn, ir, ba);
      total_cnt++; if (wr_cnt - w0 !== 2 + PAD_EN*6) $display("FAIL pad_writes: got %0d expected %0d", wr_cnt - w0, 2 + PAD_EN*6); else pass_cnt++;
      total_cnt++; if (d !== h + 1 + PAD_EN*2) $display("FAIL pad_done_cycle: got %0d expected %0d", d, h + 1 + PAD_EN*2); else pass_cnt++;
      total_cnt++; if (exp_q.size() !== 0) $display("FAIL pad_missing: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_zero_size();
      int s, h, d, hn, w0; logic ir, ba;
      w0 = wr_cnt;
      drive_load(0, 3, 0, 0, 0, s, h, d, hn, ir, ba);
      total_cnt++; if (wr_cnt - w0 !== 0) $display("FAIL zero_rows_writes: got %0d expected 0", wr_cnt - w0); else pass_cnt++;
      total_cnt++; if (d !== s + 1) $display("FAIL zero_rows_done: got %0d expected %0d", d, s + 1); else pass_cnt++;
      total_cnt++; if (ba !== 1'b0) $display("FAIL zero_rows_busy_after: got %b expected 0", ba); else pass_cnt++;
      w0 = wr_cnt;
      drive_load(3, 0, 1, 0, 0, s, h, d, hn, ir, ba);
      total_cnt++; if (wr_cnt - w0 !== 0) $display("FAIL zero_cols_writes: got %0d expected 0", wr_cnt - w0); else pass_cnt++;
      total_cnt++; if (d !== s + 1) $display("FAIL zero_cols_done: got %0d expected %0d", d, s + 1); else pass_cnt++;
   endtask

   task automatic test_clamp_rows();
      int s, h, d, hn, w0; logic ir, ba;
      w0 = wr_cnt;
      drive_load(9, 2, 1, 96, 0, s, h, d, hn, ir, ba);
      total_cnt++; if (wr_cnt - w0 !== 8) $display("FAIL clamp_writes: got %0d expected 8", wr_cnt - w0); else pass_cnt++;
      total_cnt++; if (h - s !== 8) $display("FAIL clamp_load_cycles: got %0d expected 8", h - s); else pass_cnt++;
      total_cnt++; if (d !== h + 1) $display("FAIL clamp_done_cycle: got %0d expected %0d", d, h + 1); else pass_cnt++;
      total_cnt++; if (exp_q.size() !== 0) $display("FAIL clamp_missing: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_reset_mid_load();
      int s, h, d, hn, w0; logic ir, ba; logic saw_done;
      w0 = wr_cnt;
      start = 1'b1; tile_rows = 16'd4; tile_cols = 16'd4; bankset_sel = 1'b0;
      exp_q.push_back({8'd0, 1'b0, (AW-1)'(0), W'(8'h20)});
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1; in_data = 8'h20;
      @(posedge clk); #1;
      in_data = 8'h21;
      @(posedge clk); #1;
      in_data = 8'h22;
      #1 rst = 1'b1;
      #1;
      total_cnt++; if (b_we !== '0) $display("FAIL abort_b_we: got %h expected 0", b_we); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL abort_in_ready: got %b expected 0", in_ready); else pass_cnt++;
      total_cnt++; if (b_addr !== '0) $display("FAIL abort_b_addr: got %h expected 0", b_addr); else pass_cnt++;
      total_cnt++; if (b_din !== '0) $display("FAIL abort_b_din: got %h expected 0", b_din); else pass_cnt++;
      in_valid = 1'b0;
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0) saw_done = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0) saw_done = 1'b1;
      end
      @(posedge clk); #1;
      total_cnt++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", saw_done); else pass_cnt++;
      total_cnt++; if (wr_cnt - w0 !== 1) $display("FAIL abort_writes: got %0d expected 1", wr_cnt - w0); else pass_cnt++;
      total_cnt++; if (exp_q.size() !== 0) $display("FAIL abort_missing: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
      w0 = wr_cnt;
      drive_load(2, 3, 1, 48, 0, s, h, d, hn, ir, ba);
      total_cnt++; if (wr_cnt - w0 !== 6 + PAD_EN*6) $display("FAIL reload_writes: got %0d expected %0d", wr_cnt - w0, 6 + PAD_EN*6); else pass_cnt++;
      total_cnt++; if (d !== h + 1 + PAD_EN*3) $display("FAIL reload_done_cycle: got %0d expected %0d", d, h + 1 + PAD_EN*3); else pass_cnt++;
      total_cnt++; if (exp_q.size() !== 0) $display("FAIL reload_missing: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic_2x3();
      test_bankset1_4x4();
      test_stall_2x2();
      test_pad_1x2();
      test_zero_size();
      test_clamp_rows();
      test_reset_mid_load();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tile_loader.md
# tile_loader

Write-side counterpart of `result_drain`. It accepts a row-major valid/ready stream of operand elements and writes one `tile_rows` x `tile_cols` tile into T single-port BRAM banks, one bank per tile row, so that `pe_array` can be fed from those banks. Bank addresses are split into two banksets by the address MSB, which lets one tile load while the other is consumed.

## Interface
Parameters:
- W, 8, operand element width.
- T, 4, number of banks, equal to the PE array dimension.
- AW, 8, bank address width. MSB is the bankset select; the low AW-1 bits are the column index.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin a tile load; sampled only in IDLE.
- tile_rows  in  16  rows in the tile; latched at start.
- tile_cols  in  16  columns in the tile; latched at start.
- bankset_sel  in  1  target bankset; latched at start.
- busy  out  1  high while a load is in progress.
- done  out  1  one-cycle pulse when the load completes.
- in_valid  in  1  stream element valid.
- in_data  in  W  stream element.
- in_ready  out  1  loader accepts an element this cycle.
- b_we  out  T  per-bank write strobe.
- b_addr  out  T x AW  per-bank address, {bankset, column}.
- b_din  out  T x W  per-bank write data.

## Operation
- States: IDLE, LOAD, PAD (only when the configuration macro is defined), DONE.
- IDLE → LOAD on start. At that edge the loader latches:
  - rows = min(tile_rows, T)
  - cols = min(tile_cols, 2^(AW-1))
  - bankset_sel
  - and clears r = 0, c = 0.
- IDLE → DONE on start when the clamped rows or cols equals 0. No writes are issued.
- LOAD behaviour:
  - in_ready = 1.
  - Each handshake (in_valid && in_ready) writes in_data to bank r at address {bankset, c[AW-2:0]}.
  - After each handshake c increments. When c reaches cols-1, c wraps to 0 and r increments.
- LOAD → DONE (or PAD) on the handshake of the last element, i.e. r = rows-1 and c = cols-1.
- PAD writes zeros so the unused array rows see clean operands:
  - Entered only if rows < T; otherwise the loader goes straight to DONE.
  - Runs one cycle per column c = 0..cols-1.
  - Each cycle asserts b_we[k] for every k ≥ rows at address {bankset, c}, with b_din = 0.
  - PAD → DONE after column cols-1.
- DONE → IDLE unconditionally after one cycle.
- start is ignored outside IDLE.
- in_data presented while in_ready = 0 is neither consumed nor written.
- Only one bank is strobed per cycle in LOAD. Any subset of banks may be strobed in PAD.

## Timing
- Reset values:
  - state = IDLE.
  - busy, done, in_ready = 0.
  - b_we, b_addr, b_din = 0.
  - r, c and all latched fields = 0.
- Reset asserted mid-load aborts immediately. Partial tile contents are undefined and no done pulse is produced.
- Write path is registered: a handshake in cycle N produces b_we/b_addr/b_din in cycle N+1. b_we is low in any cycle with no write.
- in_ready is a function of registered state only. It is high from the cycle after start through the cycle of the last handshake, and low from the next cycle.
- done pulses in the cycle that carries the final write strobe, so all data is committed at the end of that cycle.
  - Without PAD: done is in cycle N+1, where N is the last handshake.
  - With PAD: done is in the cycle of the last pad write.
  - Zero-size tile: done is in the cycle after start.
- busy = 1 in LOAD, PAD and DONE. busy falls in the cycle after done.
- Throughput is one element per cycle with in_valid held high. A full T x cols tile takes T*cols cycles of LOAD.
- Counters are AW-1 bits for c and clog2(T) bits for r. Clamping guarantees neither counter overflows.

## Configuration
- TILE_LOADER_ZERO_PAD_EN defined:
  - PAD state is compiled in.
  - Banks rows..T-1 are zeroed over columns 0..cols-1 after the load.
  - done is delayed by cols cycles when rows < T.
- TILE_LOADER_ZERO_PAD_EN not defined:
  - No PAD state. LOAD goes directly to DONE.
  - Banks at or above rows keep their stale contents.

## Test plan
- Load a 2x3 tile, bankset 0, stream 1..6 with in_valid held high → six writes:
  - bank0 addr 0,1,2 = 1,2,3
  - bank1 addr 0,1,2 = 4,5,6
  - done pulses with the 6th write; busy falls the next cycle.
- Load a 4x4 tile, bankset 1, values 0x10..0x1F → bank k addr 0x80+c = 0x10+4k+c. Total 16 LOAD cycles; in_ready is low after the 16th handshake.
- Load a 2x2 tile with in_valid toggling 1,0,0,1,… → exactly 4 writes, same data order as an unstalled run, no duplicate strobes.
- With TILE_LOADER_ZERO_PAD_EN, load a 1x2 tile of 7,8 → bank0 = 7,8, then 2 pad cycles zeroing banks 1..3 at addr 0,1. done is in the 2nd pad cycle.
- tile_rows=0 → no b_we, done in the cycle after start. tile_rows=9 with T=4 → treated as 4 rows.
- Assert rst during the 3rd element of a 4x4 load → all outputs 0 asynchronously, no done. A new start after reset loads correctly.
